// File: rtl/cpu_pkg.sv
// Shared constants for the writeback stage: datapath widths, instruction kinds
// and FSM state codes.
package cpu_pkg;
    localparam int CPU_DATA_W = 16;
    localparam int CPU_ADDR_W = 4;

    typedef enum logic [1:0] {
        KIND_ALU  = 2'd0,
        KIND_LOAD = 2'd1,
        KIND_MUL  = 2'd2,
        KIND_DIV  = 2'd3
    } kind_e;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MUL  = 2'd1;
    localparam logic [1:0] ST_DIV  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;
endpackage

// File: rtl/muldiv_seq.sv
// Iterative unsigned multiplier / restoring divider, one step per cycle.
// lo/hi present the result of the step being taken now, so they are final while done is high.
module muldiv_seq
    import cpu_pkg::*;
#(
    parameter int DATA_W = CPU_DATA_W,
    parameter int ITER   = DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              is_div,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic              done,
    output logic [DATA_W-1:0] lo,
    output logic [DATA_W-1:0] hi,
    output logic              dz
);
    localparam int CW = (ITER > 1) ? $clog2(ITER) : 1;

    logic              busy_reg;
    logic              div_reg;
    logic              dz_reg;
    logic [CW-1:0]     count_reg;
    logic [DATA_W-1:0] acc_hi_reg;
    logic [DATA_W-1:0] acc_lo_reg;
    logic [DATA_W-1:0] m_reg;

    logic [DATA_W:0]   sum;
    logic [DATA_W:0]   rs;
    logic [DATA_W:0]   diff;
    logic              ge;
    logic [DATA_W-1:0] hi_next;
    logic [DATA_W-1:0] lo_next;

    // MUL: {hi,lo} is the shifting product with the multiplier in lo.
    // DIV: hi is the partial remainder, lo shifts dividend out and quotient in.
    always_comb begin
        sum  = {1'b0, acc_hi_reg} + (acc_lo_reg[0] ? {1'b0, m_reg} : '0);
        rs   = {acc_hi_reg, acc_lo_reg[DATA_W-1]};
        ge   = (rs >= {1'b0, m_reg});
        diff = rs - {1'b0, m_reg};
        if (div_reg) begin
            hi_next = ge ? diff[DATA_W-1:0] : rs[DATA_W-1:0];
            lo_next = {acc_lo_reg[DATA_W-2:0], ge};
        end else begin
            hi_next = sum[DATA_W:1];
            lo_next = {sum[0], acc_lo_reg[DATA_W-1:1]};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            busy_reg   <= 1'b0;
            div_reg    <= 1'b0;
            dz_reg     <= 1'b0;
            count_reg  <= '0;
            acc_hi_reg <= '0;
            acc_lo_reg <= '0;
            m_reg      <= '0;
        end else if (start) begin
            busy_reg   <= 1'b1;
            div_reg    <= is_div;
            dz_reg     <= is_div && (b == '0);
            count_reg  <= CW'(ITER - 1);
            acc_hi_reg <= '0;
            acc_lo_reg <= is_div ? a : b;
            m_reg      <= is_div ? b : a;
        end else if (busy_reg) begin
            acc_hi_reg <= hi_next;
            acc_lo_reg <= lo_next;
            count_reg  <= count_reg - CW'(1);
            if (count_reg == '0) begin
                busy_reg <= 1'b0;
            end
        end
    end

    assign done = busy_reg && (count_reg == '0);
    assign lo   = lo_next;
    assign hi   = hi_next;
    assign dz   = dz_reg;
endmodule

// File: rtl/reg_writeback.sv
// Final pipeline stage driving the register-file write port and the R0 port.
// ALU/LOAD write one cycle after acceptance; MUL/DIV stall upstream while iterating.
module reg_writeback
    import cpu_pkg::*;
#(
    parameter int DATA_W = CPU_DATA_W,
    parameter int ADDR_W = CPU_ADDR_W,
    parameter int ITER   = DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [1:0]        in_kind,
    input  logic              in_wen,
    input  logic [ADDR_W-1:0] in_wa,
    input  logic [DATA_W-1:0] in_alu,
    input  logic [DATA_W-1:0] in_mem,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    output logic              stall,
    output logic [ADDR_W-1:0] WA1,
    output logic [DATA_W-1:0] WD1,
    output logic              RegWrite,
    output logic [DATA_W-1:0] R0D,
    output logic              R0W,
    output logic              div_zero
);
    logic [1:0]        state_reg;
    logic [ADDR_W-1:0] op_wa_reg;
    logic              op_wen_reg;
    logic [ADDR_W-1:0] wa1_reg;
    logic [DATA_W-1:0] wd1_reg;
    logic [DATA_W-1:0] r0d_reg;
    logic              regwrite_reg;
    logic              r0w_reg;
    logic              div_zero_reg;

    logic              accept;
    logic              md_start;
    logic              md_done;
    logic [DATA_W-1:0] md_lo;
    logic [DATA_W-1:0] md_hi;
    logic              md_dz;

    assign stall    = (state_reg == ST_MUL) || (state_reg == ST_DIV);
    assign accept   = in_valid && !stall;
    assign md_start = accept && in_kind[1];

    muldiv_seq #(
        .DATA_W (DATA_W),
        .ITER   (ITER)
    ) u_muldiv (
        .clk    (clk),
        .rst    (rst),
        .start  (md_start),
        .is_div (in_kind == KIND_DIV),
        .a      (in_a),
        .b      (in_b),
        .done   (md_done),
        .lo     (md_lo),
        .hi     (md_hi),
        .dz     (md_dz)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg    <= ST_IDLE;
            op_wa_reg    <= '0;
            op_wen_reg   <= 1'b0;
            wa1_reg      <= '0;
            wd1_reg      <= '0;
            r0d_reg      <= '0;
            regwrite_reg <= 1'b0;
            r0w_reg      <= 1'b0;
            div_zero_reg <= 1'b0;
        end else begin
            regwrite_reg <= 1'b0;
            r0w_reg      <= 1'b0;
            div_zero_reg <= 1'b0;
            if (stall) begin
                if (md_done) begin
                    regwrite_reg <= op_wen_reg && (op_wa_reg != '0);
                    wa1_reg      <= op_wa_reg;
                    wd1_reg      <= md_lo;
                    r0d_reg      <= md_hi;
                    r0w_reg      <= 1'b1;
                    div_zero_reg <= md_dz;
                    state_reg    <= ST_DONE;
                end
            end else if (accept) begin
                // DONE accepts like IDLE, so both fall through here.
                if (in_kind[1]) begin
                    op_wa_reg  <= in_wa;
                    op_wen_reg <= in_wen;
                    state_reg  <= (in_kind == KIND_DIV) ? ST_DIV : ST_MUL;
                end else begin
                    regwrite_reg <= in_wen && (in_wa != '0);
                    wa1_reg      <= in_wa;
                    wd1_reg      <= (in_kind == KIND_LOAD) ? in_mem : in_alu;
                    state_reg    <= ST_IDLE;
                end
            end else begin
                state_reg <= ST_IDLE;
            end
        end
    end

    assign WA1      = wa1_reg;
    assign WD1      = wd1_reg;
    assign RegWrite = regwrite_reg;
    assign R0D      = r0d_reg;
    assign R0W      = r0w_reg;
    assign div_zero = div_zero_reg;
endmodule

// File: tb/tb_reg_writeback.sv
// Directed bench for reg_writeback: a per-cycle expectation table filled from
// arithmetic on each presented instruction, checked every cycle, plus literal pins.
module tb_reg_writeback;
    localparam int MAXC = 512;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [1:0]  in_kind;
    logic        in_wen;
    logic [3:0]  in_wa;
    logic [15:0] in_alu;
    logic [15:0] in_mem;
    logic [15:0] in_a;
    logic [15:0] in_b;
    logic        stall;
    logic [3:0]  WA1;
    logic [15:0] WD1;
    logic        RegWrite;
    logic [15:0] R0D;
    logic        R0W;
    logic        div_zero;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    bit          e_stall [MAXC];
    bit          e_rw    [MAXC];
    bit          e_r0w   [MAXC];
    bit          e_dz    [MAXC];
    bit          e_zero  [MAXC];
    logic [3:0]  e_wa    [MAXC];
    logic [15:0] e_wd    [MAXC];
    logic [15:0] e_r0d   [MAXC];

    reg_writeback dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_kind  (in_kind),
        .in_wen   (in_wen),
        .in_wa    (in_wa),
        .in_alu   (in_alu),
        .in_mem   (in_mem),
        .in_a     (in_a),
        .in_b     (in_b),
        .stall    (stall),
        .WA1      (WA1),
        .WD1      (WD1),
        .RegWrite (RegWrite),
        .R0D      (R0D),
        .R0W      (R0W),
        .div_zero (div_zero)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    // Expected behaviour of one instruction presented in cycle c.
    function automatic void model_issue(input int c, input logic [1:0] k, input logic wen,
                                        input logic [3:0] wa, input logic [15:0] alu,
                                        input logic [15:0] mem, input logic [15:0] a,
                                        input logic [15:0] b);
        logic [31:0] p;
        logic [15:0] lo;
        logic [15:0] hi;
        bit          z;
        if (e_stall[c]) return;
        if (k < 2'd2) begin
            e_rw[c+1] = wen && (wa != 0);
            e_wa[c+1] = wa;
            e_wd[c+1] = (k == 2'd0) ? alu : mem;
        end else begin
            z = 0;
            if (k == 2'd2) begin
                p  = {16'h0, a} * {16'h0, b};
                lo = p[15:0];
                hi = p[31:16];
            end else if (b == 0) begin
                lo = 16'hFFFF;
                hi = a;
                z  = 1;
            end else begin
                lo = a / b;
                hi = a % b;
            end
            for (int i = 1; i <= 16; i++) e_stall[c+i] = 1;
            e_rw[c+17]  = wen && (wa != 0);
            e_wa[c+17]  = wa;
            e_wd[c+17]  = lo;
            e_r0w[c+17] = 1;
            e_r0d[c+17] = hi;
            e_dz[c+17]  = z;
        end
    endfunction

    function automatic void model_reset(input int c);
        for (int i = c + 1; i < MAXC; i++) begin
            e_stall[i] = 0; e_rw[i] = 0; e_r0w[i] = 0; e_dz[i] = 0; e_zero[i] = 0;
        end
        e_zero[c+1] = 1;
    endfunction

    always @(negedge clk) begin
        if (cyc >= 1 && cyc < MAXC) begin
            chk("stall", 32'(stall), 32'(e_stall[cyc]));
            chk("RegWrite", 32'(RegWrite), 32'(e_rw[cyc]));
            chk("R0W", 32'(R0W), 32'(e_r0w[cyc]));
            chk("div_zero", 32'(div_zero), 32'(e_dz[cyc]));
            if (e_rw[cyc]) begin
                chk("WA1", 32'(WA1), 32'(e_wa[cyc]));
                chk("WD1", 32'(WD1), 32'(e_wd[cyc]));
            end
            if (e_r0w[cyc]) chk("R0D", 32'(R0D), 32'(e_r0d[cyc]));
            if (e_zero[cyc]) begin
                chk("WA1_rst", 32'(WA1), 32'h0);
                chk("WD1_rst", 32'(WD1), 32'h0);
                chk("R0D_rst", 32'(R0D), 32'h0);
            end
        end
    end

    task automatic op(input logic [1:0] k, input logic wen, input logic [3:0] wa,
                      input logic [15:0] alu, input logic [15:0] mem,
                      input logic [15:0] a, input logic [15:0] b);
        in_valid = 1; in_kind = k; in_wen = wen; in_wa = wa;
        in_alu = alu; in_mem = mem; in_a = a; in_b = b;
        model_issue(cyc, k, wen, wa, alu, mem, a, b);
        @(posedge clk); #1;
        in_valid = 0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) begin
            rst = 0;
            model_reset(cyc);
            @(posedge clk); #1;
        end
        rst = 1;
    endtask

    initial begin
        in_valid = 0; in_kind = 0; in_wen = 0; in_wa = 0;
        in_alu = 0; in_mem = 0; in_a = 0; in_b = 0; rst = 0;
        do_reset(3);
        chk("reset_stall", 32'(stall), 32'h0);
        chk("reset_RegWrite", 32'(RegWrite), 32'h0);

        // ALU to r3
        op(2'd0, 1, 4'd3, 16'h1234, 16'h0, 16'h0, 16'h0);
        chk("alu_RegWrite", 32'(RegWrite), 32'h1);
        chk("alu_WA1", 32'(WA1), 32'h3);
        chk("alu_WD1", 32'(WD1), 32'h1234);
        chk("alu_R0W", 32'(R0W), 32'h0);
        idle(1);
        chk("alu_RegWrite_off", 32'(RegWrite), 32'h0);

        // LOAD to r0 then r5, back to back
        op(2'd1, 1, 4'd0, 16'h0, 16'hBEEF, 16'h0, 16'h0);
        chk("ld0_RegWrite", 32'(RegWrite), 32'h0);
        chk("ld0_R0W", 32'(R0W), 32'h0);
        op(2'd1, 1, 4'd5, 16'h0, 16'hBEEF, 16'h0, 16'h0);
        chk("ld5_RegWrite", 32'(RegWrite), 32'h1);
        chk("ld5_WD1", 32'(WD1), 32'hBEEF);
        op(2'd0, 0, 4'd6, 16'h7777, 16'h0, 16'h0, 16'h0);
        chk("nowen_RegWrite", 32'(RegWrite), 32'h0);

        // MUL, ALU presented in the DONE cycle
        op(2'd2, 1, 4'd7, 16'h0, 16'h0, 16'h0F00, 16'h0050);
        chk("mul_stall_first", 32'(stall), 32'h1);
        idle(15);
        chk("mul_stall_last", 32'(stall), 32'h1);
        idle(1);
        chk("mul_RegWrite", 32'(RegWrite), 32'h1);
        chk("mul_WA1", 32'(WA1), 32'h7);
        chk("mul_WD1", 32'(WD1), 32'hB000);
        chk("mul_R0W", 32'(R0W), 32'h1);
        chk("mul_R0D", 32'(R0D), 32'h0004);
        chk("mul_done_stall", 32'(stall), 32'h0);
        op(2'd0, 1, 4'd9, 16'h55AA, 16'h0, 16'h0, 16'h0);
        chk("post_mul_alu_WD1", 32'(WD1), 32'h55AA);
        chk("post_mul_alu_R0W", 32'(R0W), 32'h0);

        // DIV, with a MUL presented mid-stall that must be dropped
        op(2'd3, 1, 4'd2, 16'h0, 16'h0, 16'hFFFF, 16'h0024);
        idle(4);
        op(2'd2, 1, 4'd8, 16'h0, 16'h0, 16'h1111, 16'h2222);
        idle(11);
        chk("div_WD1", 32'(WD1), 32'h071C);
        chk("div_R0D", 32'(R0D), 32'h000F);
        chk("div_dz", 32'(div_zero), 32'h0);
        idle(2);

        // DIV by zero
        op(2'd3, 1, 4'd4, 16'h0, 16'h0, 16'h00FF, 16'h0000);
        idle(16);
        chk("dz_WD1", 32'(WD1), 32'hFFFF);
        chk("dz_R0D", 32'(R0D), 32'h00FF);
        chk("dz_flag", 32'(div_zero), 32'h1);
        chk("dz_R0W", 32'(R0W), 32'h1);
        idle(1);
        chk("dz_flag_off", 32'(div_zero), 32'h0);

        // MUL into r0: only R0 port written
        op(2'd2, 1, 4'd0, 16'h0, 16'h0, 16'hFFFF, 16'hFFFF);
        idle(16);
        chk("mulr0_RegWrite", 32'(RegWrite), 32'h0);
        chk("mulr0_R0D", 32'(R0D), 32'hFFFE);
        idle(1);

        op(2'd3, 1, 4'd1, 16'h0, 16'h0, 16'd100, 16'd7);
        idle(18);

        // Reset at iteration 8 of a MUL
        op(2'd2, 1, 4'd7, 16'h0, 16'h0, 16'h0F00, 16'h0050);
        idle(7);
        do_reset(1);
        chk("rstmid_stall", 32'(stall), 32'h0);
        chk("rstmid_RegWrite", 32'(RegWrite), 32'h0);
        chk("rstmid_R0W", 32'(R0W), 32'h0);
        chk("rstmid_WD1", 32'(WD1), 32'h0);
        idle(20);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
